// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
// Holds the funct3 encodings and the FSM state type.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and for the final result sign.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign data_o = neg_i ? (~data_i + ONE) : data_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift-add or restoring-divide step per cycle.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_in,
  input  logic [2:0]      fun_3_in,
  input  logic [XLEN-1:0] data_1_in,
  input  logic [XLEN-1:0] data_2_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] ITER = CW'(XLEN);
  localparam logic [CW-1:0] LAST = CW'(1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   res_q;
  logic              done_q;

  logic            accept;
  logic            is_div;
  logic            s1, s2;
  logic            div0, ovf, special;
  logic            neg_in;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_n;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   rem_n, quo_n;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              lo_sel;
  logic [XLEN-1:0]   res_fin;

  assign accept = (state_q == IDLE) & start_in & ~flush_in;
  assign is_div = fun_3_in[2];

  // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 signed only for MUL/MULH/DIV/REM
  assign s1 = data_1_in[XLEN-1]
            & ~((fun_3_in == F3_MULHU) | (fun_3_in == F3_DIVU)
              | (fun_3_in == F3_REMU));
  assign s2 = data_2_in[XLEN-1]
            & ((fun_3_in == F3_MUL) | (fun_3_in == F3_MULH)
             | (fun_3_in == F3_DIV) | (fun_3_in == F3_REM));

  assign div0 = is_div & (data_2_in == '0);
  assign ovf  = is_div & ~fun_3_in[0]
              & (data_1_in == MINV) & (data_2_in == '1);
  assign special = div0 | ovf;

  // remainder takes the dividend's sign, everything else s1^s2
  assign neg_in = (fun_3_in[2] & fun_3_in[1]) ? s1 : (s1 ^ s2);

  muldiv_sign_fix #(.W(XLEN)) u_abs1 (
    .neg_i  (s1),
    .data_i (data_1_in),
    .data_o (mag1)
  );

  muldiv_sign_fix #(.W(XLEN)) u_abs2 (
    .neg_i  (s2),
    .data_i (data_2_in),
    .data_o (mag2)
  );

  // early result for divide-by-zero and signed overflow
  always_comb begin
    spec_res = '1;
    if (div0) spec_res = fun_3_in[1] ? data_1_in : '1;
    else      spec_res = fun_3_in[1] ? '0 : data_1_in;
  end

  // one iteration of shift-add multiply and restoring divide
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
          + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_n = {sum, acc_q[XLEN-1:1]};
    diff  = {rem_q, acc_q[XLEN-1]} - {1'b0, b_q};
    ge    = ~diff[XLEN];
    rem_n = ge ? diff[XLEN-1:0]
               : {rem_q[XLEN-2:0], acc_q[XLEN-1]};
    quo_n = {acc_q[XLEN-2:0], ge};
  end

  assign fix_in = f3_q[2]
                ? {{XLEN{1'b0}}, (f3_q[1] ? rem_n : quo_n)}
                : mul_n;

  muldiv_sign_fix #(.W(2*XLEN)) u_res (
    .neg_i  (neg_q),
    .data_i (fix_in),
    .data_o (fix_out)
  );

  assign lo_sel  = f3_q[2] | (f3_q == F3_MUL);
  assign res_fin = lo_sel ? fix_out[XLEN-1:0]
                          : fix_out[2*XLEN-1:XLEN];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start_in) state_d = special ? DONE : CALC;
        CALC: if (cnt_q == LAST) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // stall request: raised combinationally on accept, held through CALC
  always_comb begin
    busy_out = accept | (state_q == CALC);
  end

  // operand latch, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_in) begin
        cnt_q <= '0;
      end else if (accept) begin
        f3_q  <= fun_3_in;
        neg_q <= neg_in;
        b_q   <= is_div ? mag2 : mag1;
        acc_q <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
        rem_q <= '0;
        cnt_q <= special ? '0 : ITER;
        if (special) begin
          res_q  <= spec_res;
          done_q <= 1'b1;
        end
      end else if (state_q == CALC) begin
        acc_q <= f3_q[2] ? {acc_q[2*XLEN-1:XLEN], quo_n} : mul_n;
        rem_q <= rem_n;
        cnt_q <= cnt_q - LAST;
        if (cnt_q == LAST) begin
          res_q  <= res_fin;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_out   = done_q;
  assign result_out = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized bench for ex_muldiv_unit.
// Expected values come from spec constants and a plain-arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [2:0]  fun_3_in;
  logic [31:0] data_1_in;
  logic [31:0] data_2_in;
  logic        flush_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] result_out;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .fun_3_in   (fun_3_in),
    .data_1_in  (data_1_in),
    .data_2_in  (data_2_in),
    .flush_in   (flush_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // cycle 1 = the cycle start_in is first presented
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat, output int nbusy,
                       output bit got);
    int cyc;
    @(negedge clk);
    start_in = 1'b1;
    fun_3_in = f3;
    data_1_in = a;
    data_2_in = b;
    #1;
    cyc = 1;
    nbusy = busy_out ? 1 : 0;
    lat = 0;
    res = '0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy_out) nbusy++;
      if (done_out) begin
        got = 1'b1;
        lat = cyc;
        res = result_out;
        start_in = 1'b0;
      end
    end
    start_in = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    logic [31:0] res;
    int lat, nbusy;
    bit got, sp;
    sp = is_special(f3, a, b);
    do_op(f3, a, b, res, lat, nbusy, got);
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, 32'(lat), sp ? 32'd2 : 32'd34);
    chk({tag, "_busy"}, 32'(nbusy), sp ? 32'd1 : 32'd33);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done_out), 32'd0);
  endtask

  task automatic no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_out) cnt++;
    end
    chk(tag, 32'(cnt), 32'd0);
  endtask

  logic [31:0] last_exp;
  logic [31:0] r1, r2;
  logic [2:0]  rf3;
  logic [31:0] ra, rb;
  int cyc, n, t1, t2;

  initial begin
    reset = 1'b1;
    start_in = 1'b0;
    fun_3_in = '0;
    data_1_in = '0;
    data_2_in = '0;
    flush_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_result", result_out, 32'h0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);

    exec("mul_7xm3", 3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    exec("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    exec("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    exec("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    exec("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    exec("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
    exec("div_5_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    exec("rem_5_0", 3'd6, 32'd5, 32'd0, 32'd5);
    exec("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    exec("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    exec("mul_zero", 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    exec("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    last_exp = 32'd14;

    // flush in CALC at cycle 10
    @(negedge clk);
    start_in = 1'b1;
    fun_3_in = 3'd0;
    data_1_in = 32'd9;
    data_2_in = 32'd9;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    flush_in = 1'b1;
    start_in = 1'b0;
    @(negedge clk);
    flush_in = 1'b0;
    #1;
    chk("flush_busy", 32'(busy_out), 32'd0);
    no_done("flush_nodone", 40);
    chk("flush_hold", result_out, last_exp);

    // flush and start together in IDLE
    @(negedge clk);
    start_in = 1'b1;
    flush_in = 1'b1;
    #1;
    chk("flush_start_busy", 32'(busy_out), 32'd0);
    @(negedge clk);
    start_in = 1'b0;
    flush_in = 1'b0;
    no_done("flush_start_nodone", 40);
    chk("flush_start_hold", result_out, last_exp);

    // reset at cycle 10
    @(negedge clk);
    start_in = 1'b1;
    fun_3_in = 3'd5;
    data_1_in = 32'd1000;
    data_2_in = 32'd3;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    start_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_result", result_out, 32'h0);
    chk("midrst_done", 32'(done_out), 32'd0);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    no_done("midrst_nodone", 40);

    // back-to-back MULs, start held through DONE
    @(negedge clk);
    start_in = 1'b1;
    fun_3_in = 3'd0;
    data_1_in = 32'd3;
    data_2_in = 32'd5;
    cyc = 1;
    n = 0;
    t1 = 0;
    t2 = 0;
    r1 = '0;
    r2 = '0;
    while (n < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_out) begin
        n++;
        if (n == 1) begin
          t1 = cyc;
          r1 = result_out;
          data_1_in = 32'hFFFF_FFFE;
          data_2_in = 32'd11;
        end else begin
          t2 = cyc;
          r2 = result_out;
          start_in = 1'b0;
        end
      end
    end
    start_in = 1'b0;
    chk("b2b_count", 32'(n), 32'd2);
    chk("b2b_t1", 32'(t1), 32'd34);
    chk("b2b_gap", 32'(t2 - t1), 32'd34);
    chk("b2b_r1", r1, 32'd15);
    chk("b2b_r2", r2, 32'hFFFF_FFEA);
    no_done("b2b_nodone", 40);

    // randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = rnd_val();
      rb = rnd_val();
      exec($sformatf("rnd%0d_f%0d", i, rf3), rf3, ra, rb,
           ref_op(rf3, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
